// File: rtl/nn_pkg.sv
// Shared neural-datapath constants and types.
// Holds accumulator/operand widths, the MAC engine state enum and the
// saturation limits used by the accumulator and downstream activation stage.
package nn_pkg;

    localparam int unsigned ACC_W  = 32;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned PROD_W = 2 * DATA_W;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } mac_state_t;

endpackage : nn_pkg

// File: rtl/sat_add32.sv
// Combinational saturating adder: acc + sign-extended product, clamped to
// the signed ACC_W range instead of wrapping.
// Ports:
//   acc  - signed ACC_W running value
//   prod - signed PROD_W product
//   sum  - signed ACC_W saturated result
module sat_add32
    import nn_pkg::*;
(
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [PROD_W-1:0] prod,
    output logic signed [ACC_W-1:0]  sum
);

    localparam int unsigned EXT_W = ACC_W + 1;

    logic [EXT_W-1:0] sum_ext;

    // One guard bit is enough: |prod| is far below 2^31.
    assign sum_ext = {acc[ACC_W-1], acc}
                   + {{(EXT_W-PROD_W){prod[PROD_W-1]}}, prod};

    // Guard bit disagreeing with the sign bit means overflow; guard gives direction.
    always_comb begin
        sum = sum_ext[ACC_W-1:0];
        case (sum_ext[EXT_W-1 -: 2])
            2'b01:   sum = ACC_MAX;
            2'b10:   sum = ACC_MIN;
            default: sum = sum_ext[ACC_W-1:0];
        endcase
    end

endmodule : sat_add32

// File: rtl/neuron_mac.sv
// Sequential int8 multiply-accumulate engine for one neuron.
// Loads bias on start, accumulates len act*weight products with int32
// saturation, then presents the result on a valid/ready handshake.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   start, bias, len    - neuron launch (sampled in IDLE only)
//   clear               - synchronous abort to IDLE, acc cleared
//   in_valid, in_ready  - operand pair handshake (act, weight)
//   out_valid, out_ready- result handshake
//   accumulator         - running / final sum
//   busy                - high in ACCUM or DONE
module neuron_mac
    import nn_pkg::*;
#(
    parameter int unsigned LEN_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [ACC_W-1:0]  bias,
    input  logic [LEN_W-1:0]         len,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] act,
    input  logic signed [DATA_W-1:0] weight,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  accumulator,
    output logic                     busy
);

    mac_state_t               state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [LEN_W-1:0]         cnt_q, cnt_d;
    logic                     in_ready_d, out_valid_d, busy_d;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [ACC_W-1:0]  sum_c;

    // Full-precision signed product; fits PROD_W without loss.
    assign prod_c = act * weight;

    sat_add32 u_sat_add32 (
        .acc  (acc_q),
        .prod (prod_c),
        .sum  (sum_c)
    );

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
        end
    end

    // Next-state, datapath update and decode of next-state into status flags.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;

        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_d   = bias;
                        cnt_d   = len;
                        state_d = (len == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid && in_ready) begin
                        acc_d = sum_c;
                        cnt_d = cnt_q - LEN_W'(1);
                        if (cnt_q == LEN_W'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Flags are registered copies of the next-state decode.
        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == ACCUM) || (state_d == DONE);
    end

    assign accumulator = acc_q;

endmodule : neuron_mac

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac: driver pushes reference results into a
// scoreboard queue, a negedge monitor pops and compares on each handshake.
module tb_neuron_mac;

    localparam int unsigned LEN_W = 8;
    localparam longint SAT_MAX = 64'sd2147483647;
    localparam longint SAT_MIN = -64'sd2147483648;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic signed [31:0] bias;
    logic [LEN_W-1:0]   len;
    logic               clear;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  act;
    logic signed [7:0]  weight;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] accumulator;
    logic               busy;

    int  errors;
    int  checks;
    int  handshakes;
    int  expected_hs;
    int  exp_q[$];
    byte a_q[$];
    byte w_q[$];

    neuron_mac #(.LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .bias        (bias),
        .len         (len),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .act         (act),
        .weight      (weight),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .accumulator (accumulator),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference: bias plus each product in order, clamped to int32 after every step.
    function automatic int model(input int b, input int n);
        longint s;
        s = longint'(b);
        for (int i = 0; i < n; i++) begin
            s = s + longint'(a_q[i]) * longint'(w_q[i]);
            if (s > SAT_MAX) s = SAT_MAX;
            if (s < SAT_MIN) s = SAT_MIN;
        end
        return int'(s);
    endfunction

    // Scoreboard monitor: a handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            handshakes++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0d, expected no result", accumulator);
            end else begin
                chk("result", longint'(accumulator), longint'(exp_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full neuron: start, n beats with `gap` idle cycles before each,
    // `hold` cycles of backpressure (start pulsed meanwhile), then handshake.
    task automatic run_neuron(input int b, input int n, input int gap, input int hold);
        int want;
        want = model(b, n);
        exp_q.push_back(want);
        expected_hs++;
        start = 1'b1;
        bias  = b;
        len   = LEN_W'(n);
        step();
        start = 1'b0;
        if (n == 0) chk("len0_in_ready", longint'(in_ready), 0);
        else        chk("accum_in_ready", longint'(in_ready), 1);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                step();
                chk("gap_busy", longint'(busy), 1);
            end
            in_valid = 1'b1;
            act      = a_q[i];
            weight   = w_q[i];
            step();
            in_valid = 1'b0;
        end
        chk("done_out_valid", longint'(out_valid), 1);
        chk("done_in_ready", longint'(in_ready), 0);
        chk("done_busy", longint'(busy), 1);
        for (int h = 0; h < hold; h++) begin
            start = 1'b1;
            bias  = int'($urandom);
            len   = LEN_W'(1);
            step();
            chk("hold_out_valid", longint'(out_valid), 1);
            chk("hold_acc", longint'(accumulator), longint'(want));
        end
        start     = (hold > 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        start     = 1'b0;
        chk("idle_out_valid", longint'(out_valid), 0);
        chk("idle_busy", longint'(busy), 0);
        chk("idle_acc_kept", longint'(accumulator), longint'(want));
    endtask

    // Launch a 4-beat neuron, feed one beat, then abort via reset or clear.
    task automatic abort_then_nine(input bit use_reset);
        start = 1'b1;
        bias  = 32'sd12345;
        len   = LEN_W'(4);
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        act      = 8'sd5;
        weight   = 8'sd6;
        step();
        in_valid = 1'b0;
        chk("abort_busy_before", longint'(busy), 1);
        if (use_reset) begin
            rst_n = 1'b0;
            #1;
            chk("rst_acc", longint'(accumulator), 0);
            chk("rst_out_valid", longint'(out_valid), 0);
            chk("rst_in_ready", longint'(in_ready), 0);
            chk("rst_busy", longint'(busy), 0);
            @(negedge clk);
            rst_n = 1'b1;
            step();
        end else begin
            clear = 1'b1;
            #1;
            chk("clear_not_async", longint'(busy), 1);
            step();
            clear = 1'b0;
            chk("clr_acc", longint'(accumulator), 0);
            chk("clr_out_valid", longint'(out_valid), 0);
            chk("clr_in_ready", longint'(in_ready), 0);
            chk("clr_busy", longint'(busy), 0);
        end
        a_q = '{8'sd3};
        w_q = '{8'sd3};
        run_neuron(0, 1, 0, 0);
    endtask

    initial begin
        int b;
        int n;
        errors      = 0;
        checks      = 0;
        handshakes  = 0;
        expected_hs = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        bias      = '0;
        len       = '0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        act       = '0;
        weight    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_acc", longint'(accumulator), 0);
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_in_ready", longint'(in_ready), 0);
        chk("reset_busy", longint'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Directed cases.
        a_q = '{8'sd2, -8'sd4, 8'sd127};
        w_q = '{8'sd3, 8'sd5, 8'sd127};
        run_neuron(10, 3, 0, 0);
        run_neuron(-7, 0, 0, 0);
        a_q = '{8'sd127};
        w_q = '{8'sd127};
        run_neuron(2147483000, 1, 0, 0);
        a_q = '{-8'sd128};
        w_q = '{8'sd127};
        run_neuron(-2147483600, 1, 0, 0);
        a_q = '{-8'sd128};
        w_q = '{-8'sd128};
        run_neuron(0, 1, 0, 0);
        a_q = '{8'sd100, -8'sd77};
        w_q = '{-8'sd50, -8'sd99};
        run_neuron(1000, 2, 3, 5);

        abort_then_nine(1'b1);
        abort_then_nine(1'b0);

        // Randomized neurons, biased towards the saturation boundaries.
        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 3))
                0:       b = 2147483647 - int'($urandom_range(0, 40000));
                1:       b = -2147483647 + int'($urandom_range(0, 40000));
                default: b = int'($urandom);
            endcase
            n = int'($urandom_range(0, 6));
            a_q.delete();
            w_q.delete();
            for (int i = 0; i < n; i++) begin
                a_q.push_back(byte'($urandom));
                w_q.push_back(byte'($urandom));
            end
            run_neuron(b, n, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        repeat (2) step();
        chk("scoreboard_drained", longint'(exp_q.size()), 0);
        chk("handshake_count", longint'(handshakes), longint'(expected_hs));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_neuron_mac
